// File: rtl/packed_bus_serializer.sv
// packed_bus_serializer
//   Takes one flat bus of N WIDTH-bit words (element k at bits
//   [WIDTH*(k+1)-1 : WIDTH*k]) and streams the words one per beat on a
//   valid/ready interface. Each beat is tagged with its element index and
//   flags the final beat of the vector. When an accept lands on the last beat,
//   the next vector is loaded with no idle cycle, giving 1 beat/cycle.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   in_bus/in_valid/in_ready    packed vector input handshake
//   out_data/out_idx/out_last   current beat (word, original index, final flag)
//   out_valid/out_ready         output beat handshake
//   busy                        a vector is held (state SEND)
//
// Optional feature macro: SKIP_ZERO_EN
//   When defined, zero elements are dropped. out_idx still reports the
//   original index, and out_last marks the highest nonzero element. An
//   all-zero vector is accepted but produces no beats.

// Per-lane word select: a lane drives its word only when the index matches.
// The lane outputs are OR-reduced to form the output mux.
module pbs_lane #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] sel_word
);
  assign sel_word = (idx == IDX_W'(LANE)) ? word : '0;
endmodule

module packed_bus_serializer #(
  parameter  int N     = 4,
  parameter  int WIDTH = 16,
  localparam int IDX_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH*N-1:0] in_bus,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [N-1:0][WIDTH-1:0]  in_words, hold_q, lane_word;
  logic [WIDTH-1:0]         sel_word;
  logic [IDX_W-1:0]         cur_idx;
  logic                     is_last, beat, accept, go_send;

  assign in_words = in_bus;

  assign beat     = (state_q == SEND) & out_ready;
  // Accept either when idle, or on the last beat so the next vector follows directly.
  assign in_ready = (state_q == IDLE) | (beat & is_last);
  assign accept   = in_valid & in_ready;

`ifdef SKIP_ZERO_EN
  // mask_q holds the elements still to send. The current beat is the lowest
  // set bit. It is the last beat when exactly one bit remains.
  logic [N-1:0] in_mask, mask_q;

  always_comb begin
    in_mask = '0;
    for (int k = 0; k < N; k++) in_mask[k] = |in_words[k];
  end

  always_comb begin
    cur_idx = '0;
    for (int k = N-1; k >= 0; k--)
      if (mask_q[k]) cur_idx = IDX_W'(k);
  end

  assign is_last = (mask_q & (mask_q - N'(1))) == '0;
  assign go_send = |in_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '0;
    else if (accept) mask_q <= in_mask;
    else if (beat)   mask_q <= mask_q & (mask_q - N'(1));
  end
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  logic [IDX_W-1:0] idx_q;

  assign cur_idx = idx_q;
  assign is_last = (idx_q == LAST_IDX);
  assign go_send = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                idx_q <= '0;
    else if (accept)           idx_q <= '0;
    else if (beat && !is_last) idx_q <= idx_q + 1'b1;
  end
`endif

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)              state_d = go_send ? SEND : IDLE;
    else if (beat & is_last) state_d = IDLE;
  end

  // Output data always comes from the holding register, so in_bus can change
  // freely while a vector is being sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (accept) hold_q <= in_words;
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    pbs_lane #(.WIDTH(WIDTH), .IDX_W(IDX_W), .LANE(k)) u_lane (
      .word     (hold_q[k]),
      .idx      (cur_idx),
      .sel_word (lane_word[k])
    );
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N; k++) sel_word = sel_word | lane_word[k];
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = out_valid ? sel_word : '0;
  assign out_idx   = out_valid ? cur_idx  : '0;
  assign out_last  = out_valid & is_last;

endmodule

// File: tb/tb_packed_bus_serializer.sv
module tb_packed_bus_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=4, WIDTH=16 instance
  logic [63:0] in_bus;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last, out_valid, out_ready, busy;

  packed_bus_serializer #(.N(4), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // N=1 instance
  logic [15:0] b1, od1;
  logic [0:0]  oi1;
  logic        v1, r1, ol1, ov1, or1, busy1;

  packed_bus_serializer #(.N(1), .WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_bus(b1), .in_valid(v1),
    .in_ready(r1), .out_data(od1), .out_idx(oi1),
    .out_last(ol1), .out_valid(ov1), .out_ready(or1), .busy(busy1)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  i;
    logic        l;
  } beat_t;

  beat_t q[$];          // expected beats still owed by dut
  logic        p1;      // dut1 holds a word
  logic [15:0] d1;
  int c_total = 0;
  int c_err   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    c_total++;
    if (got !== exp) begin
      c_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected beat list for a vector, built straight from the element rules.
  function automatic void push_vec(input logic [63:0] v);
    int hi = -1;
    logic [15:0] w;
    logic keep;
    for (int k = 0; k < 4; k++) begin
      w = v[16*k +: 16];
      keep = 1'b1;
`ifdef SKIP_ZERO_EN
      keep = (w != 16'h0);
`endif
      if (keep) hi = k;
    end
    for (int k = 0; k < 4; k++) begin
      w = v[16*k +: 16];
      keep = 1'b1;
`ifdef SKIP_ZERO_EN
      keep = (w != 16'h0);
`endif
      if (keep) q.push_back('{d: w, i: 2'(k), l: (k == hi)});
    end
  endfunction

  // One clock of the N=4 instance: drive, check against model, advance model.
  task automatic cycle(input logic vld, input logic [63:0] bus, input logic ordy,
                       output logic acc);
    logic  exp_rdy;
    beat_t h;
    @(negedge clk);
    in_valid = vld; in_bus = bus; out_ready = ordy;
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("busy",      busy,      q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk("out_data", out_data, h.d);
      chk("out_idx",  out_idx,  h.i);
      chk("out_last", out_last, h.l);
    end
    acc = vld & exp_rdy;
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (acc) push_vec(bus);
  endtask

  // Offer a vector with in_valid held until accepted (bounded).
  task automatic send(input logic [63:0] v);
    logic acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, v, 1'b1, acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic cycle1(input logic vld, input logic [15:0] bus, input logic ordy);
    logic exp_rdy, keep;
    @(negedge clk);
    v1 = vld; b1 = bus; or1 = ordy;
    #1;
    exp_rdy = !p1 || ordy;
    chk("n1_in_ready",  r1,    exp_rdy);
    chk("n1_out_valid", ov1,   p1);
    chk("n1_busy",      busy1, p1);
    if (p1) begin
      chk("n1_out_data", od1, d1);
      chk("n1_out_idx",  oi1, 0);
      chk("n1_out_last", ol1, 1);
    end
    if (p1 && ordy) p1 = 1'b0;
    keep = 1'b1;
`ifdef SKIP_ZERO_EN
    keep = (bus != 16'h0);
`endif
    if (vld && exp_rdy && keep) begin p1 = 1'b1; d1 = bus; end
  endtask

  function automatic logic [63:0] rand_vec();
    logic [63:0] v;
    for (int k = 0; k < 4; k++)
      v[16*k +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    return v;
  endfunction

  initial begin
    logic        acc;
    logic        hold_vld;
    logic [63:0] hold_bus;
    rst_n = 1'b0; in_bus = '0; in_valid = 1'b0; out_ready = 1'b0;
    b1 = '0; v1 = 1'b0; or1 = 1'b0; p1 = 1'b0; d1 = '0;
    #2;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_n1_ready",  r1,        1);
    @(negedge clk); rst_n = 1'b1;

    // Ascending vector, full throughput.
    cycle(1'b1, 64'h0004_0003_0002_0001, 1'b1, acc);
    chk("accept_first", acc, 1);
    for (int t = 0; t < 5; t++) cycle(1'b0, '0, 1'b1, acc);

    // Stall on idx 1 with in_bus changing underneath.
    cycle(1'b1, 64'h0004_0003_0002_0001, 1'b1, acc);
    cycle(1'b0, 64'hDEAD_BEEF_0000_1111, 1'b1, acc);
    for (int t = 0; t < 3; t++) begin
      cycle(1'b0, 64'(rand_vec()), 1'b0, acc);
      chk("stall_data", out_data, 16'h0002);
      chk("stall_idx",  out_idx,  1);
    end
    for (int t = 0; t < 4; t++) cycle(1'b0, 64'(rand_vec()), 1'b1, acc);

    // Back-to-back: second vector is taken on the last beat of the first.
    send(64'h0004_0003_0002_0001);
    send(64'h0008_0007_0006_0005);
    for (int t = 0; t < 5; t++) cycle(1'b0, '0, 1'b1, acc);

    // Zero elements (dropped only when SKIP_ZERO_EN is defined).
    send(64'h0000_0007_0000_0005);
    for (int t = 0; t < 5; t++) cycle(1'b0, '0, 1'b1, acc);
    send(64'h0);
    for (int t = 0; t < 5; t++) cycle(1'b0, '0, 1'b1, acc);

    // Async reset in the middle of a vector.
    send(64'h0004_0003_0002_0001);
    cycle(1'b0, '0, 1'b1, acc);
    #2; rst_n = 1'b0; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy",      busy,      0);
    chk("midrst_in_ready",  in_ready,  1);
    q.delete();
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic; upstream holds in_valid/in_bus until accepted.
    hold_vld = 1'b0; hold_bus = '0;
    for (int t = 0; t < 400; t++) begin
      if (!hold_vld && $urandom_range(0, 2) != 0) begin
        hold_vld = 1'b1; hold_bus = rand_vec();
      end
      cycle(hold_vld, hold_vld ? hold_bus : 64'(rand_vec()), 1'($urandom_range(0, 3) != 0), acc);
      if (acc) hold_vld = 1'b0;
    end
    for (int t = 0; t < 12; t++) cycle(1'b0, '0, 1'b1, acc);

    // N=1 instance: single beat each, then with out_ready toggling.
    cycle1(1'b1, 16'hABCD, 1'b1);
    cycle1(1'b0, 16'h0,    1'b1);
    cycle1(1'b0, 16'h0,    1'b1);
    for (int t = 0; t < 60; t++)
      cycle1(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom),
             1'(t % 2));
    for (int t = 0; t < 3; t++) cycle1(1'b0, 16'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", c_err, c_total);
    $finish;
  end

endmodule
